// File: rtl/writeback_stage.sv
// M->W pipeline register and register-file writeback datapath of the five-stage MIPS core.
// Also flags bubbles (ValidW) and counts retired instructions for debug/CPI.
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             ValidM,
  input  logic [31:0]      InstrM,
  input  logic [31:0]      PC8M,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      ReadDataM,
  output logic [5:0]       OpW,
  input  logic             RegWriteW,
  input  logic [1:0]       RegDstW,
  input  logic [1:0]       MemtoRegW,
  output logic [31:0]      InstrW,
  output logic             ValidW,
  output logic             WE,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic [CNT_W-1:0] RetireCount
);

  logic             valid_q,     valid_d;
  logic [31:0]      instr_q,     instr_d;
  logic [31:0]      pc8_q,       pc8_d;
  logic [31:0]      alu_out_q,   alu_out_d;
  logic [31:0]      read_data_q, read_data_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             retire;

  // Flush beats stall: a squashed slot becomes the all-zero sll bubble.
  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc8_d       = pc8_q;
    alu_out_d   = alu_out_q;
    read_data_d = read_data_q;
    if (flush) begin
      valid_d     = 1'b0;
      instr_d     = 32'h0;
      pc8_d       = 32'h0;
      alu_out_d   = 32'h0;
      read_data_d = 32'h0;
    end else if (en) begin
      valid_d     = ValidM;
      instr_d     = InstrM;
      pc8_d       = PC8M;
      alu_out_d   = ALUOutM;
      read_data_d = ReadDataM;
    end
  end

  // An instruction retires only when it actually leaves W, so stalls never double-count.
  assign retire = valid_q & en & ~flush;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc8_q        <= 32'h0;
      alu_out_q    <= 32'h0;
      read_data_q  <= 32'h0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc8_q        <= pc8_d;
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    A3 = 5'd0;
    case (RegDstW)
      2'd0:    A3 = instr_q[20:16];
      2'd1:    A3 = instr_q[15:11];
      2'd2:    A3 = 5'd31;
      default: A3 = 5'd0;
    endcase
  end

  always_comb begin
    WD = 32'h0;
    case (MemtoRegW)
      2'd0:    WD = alu_out_q;
      2'd1:    WD = read_data_q;
      2'd2:    WD = {instr_q[15:0], 16'h0};
      default: WD = pc8_q;
    endcase
  end

  // RegWriteW gates first so undriven mux selects on non-writing instructions never reach WE.
  assign WE          = valid_q & RegWriteW & (A3 != 5'd0);
  assign OpW         = instr_q[31:26];
  assign InstrW      = instr_q;
  assign ValidW      = valid_q;
  assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage; a second instance with a 4-bit counter covers wrap.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, ValidM;
  logic [31:0] InstrM, PC8M, ALUOutM, ReadDataM;
  logic        RegWriteW;
  logic [1:0]  RegDstW, MemtoRegW;

  logic [5:0]  OpW,    OpW4;
  logic [31:0] InstrW, InstrW4;
  logic        ValidW, ValidW4;
  logic        WE,     WE4;
  logic [4:0]  A3,     A34;
  logic [31:0] WD,     WD4;
  logic [31:0] RetireCount;
  logic [3:0]  RetireCount4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .ValidM(ValidM),
    .InstrM(InstrM), .PC8M(PC8M), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .OpW(OpW), .RegWriteW(RegWriteW), .RegDstW(RegDstW), .MemtoRegW(MemtoRegW),
    .InstrW(InstrW), .ValidW(ValidW), .WE(WE), .A3(A3), .WD(WD),
    .RetireCount(RetireCount)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .ValidM(ValidM),
    .InstrM(InstrM), .PC8M(PC8M), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .OpW(OpW4), .RegWriteW(RegWriteW), .RegDstW(RegDstW), .MemtoRegW(MemtoRegW),
    .InstrW(InstrW4), .ValidW(ValidW4), .WE(WE4), .A3(A34), .WD(WD4),
    .RetireCount(RetireCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_m(input logic v, input logic [31:0] instr, input logic [31:0] pc8,
                        input logic [31:0] alu, input logic [31:0] rdata);
    ValidM = v; InstrM = instr; PC8M = pc8; ALUOutM = alu; ReadDataM = rdata;
  endtask

  task automatic ctl(input logic rw, input logic [1:0] dst, input logic [1:0] m2r);
    RegWriteW = rw; RegDstW = dst; MemtoRegW = m2r;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0;
    load_m(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    ctl(1'b1, 2'd2, 2'd3);
    step(); step();
    chk("rst_valid", {31'h0, ValidW}, 32'h0);
    chk("rst_instr", InstrW, 32'h0);
    chk("rst_op",    {26'h0, OpW}, 32'h0);
    chk("rst_we",    {31'h0, WE}, 32'h0);
    chk("rst_wd",    WD, 32'h0);
    chk("rst_cnt",   RetireCount, 32'h0);

    #2 rst_n = 1'b1;
    en = 1'b1;

    // ori $5,$0,0x1234
    load_m(1'b1, 32'h34051234, 32'h0, 32'h00001234, 32'h0);
    step();
    ctl(1'b1, 2'd0, 2'd0);
    chk("ori_op",  {26'h0, OpW}, 32'h0000000D);
    chk("ori_we",  {31'h0, WE}, 32'h1);
    chk("ori_a3",  {27'h0, A3}, 32'd5);
    chk("ori_wd",  WD, 32'h00001234);
    chk("ori_cnt", RetireCount, 32'd0);

    // lw $8,0($0)
    load_m(1'b1, 32'h8C080000, 32'h0, 32'h0, 32'hDEADBEEF);
    step();
    ctl(1'b1, 2'd0, 2'd1);
    chk("lw_cnt", RetireCount, 32'd1);
    chk("lw_a3",  {27'h0, A3}, 32'd8);
    chk("lw_wd",  WD, 32'hDEADBEEF);
    chk("lw_we",  {31'h0, WE}, 32'h1);

    // lui $9,0xABCD
    load_m(1'b1, 32'h3C09ABCD, 32'h0, 32'h0, 32'h0);
    step();
    ctl(1'b1, 2'd0, 2'd2);
    chk("lui_a3", {27'h0, A3}, 32'd9);
    chk("lui_wd", WD, 32'hABCD0000);

    // jal
    load_m(1'b1, 32'h0C000C00, 32'h00003008, 32'h0, 32'h0);
    step();
    ctl(1'b1, 2'd2, 2'd3);
    chk("jal_a3", {27'h0, A3}, 32'd31);
    chk("jal_wd", WD, 32'h00003008);
    chk("jal_we", {31'h0, WE}, 32'h1);
    chk("jal_cnt", RetireCount, 32'd3);

    // add $0,$0,$0
    load_m(1'b1, 32'h00000020, 32'h0, 32'h0, 32'h0);
    step();
    ctl(1'b1, 2'd1, 2'd0);
    chk("rd0_a3", {27'h0, A3}, 32'd0);
    chk("rd0_we", {31'h0, WE}, 32'h0);
    ctl(1'b1, 2'd3, 2'd0);
    chk("dst3_we", {31'h0, WE}, 32'h0);

    // sw $8,4($0) with undriven controller selects
    load_m(1'b1, 32'hAC080004, 32'h0, 32'h00000004, 32'h0);
    step();
    ctl(1'b0, 2'bxx, 2'bxx);
    chk("sw_we", {31'h0, WE}, 32'h0);

    // ori $6,$0,0x55 then 3-cycle stall
    load_m(1'b1, 32'h34060055, 32'h0, 32'h00000055, 32'h0);
    step();
    ctl(1'b1, 2'd0, 2'd0);
    chk("stl_cnt0", RetireCount, 32'd6);
    en = 1'b0;
    load_m(1'b1, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_instr", InstrW, 32'h34060055);
      chk("stl_we",    {31'h0, WE}, 32'h1);
      chk("stl_wd",    WD, 32'h00000055);
      chk("stl_cnt",   RetireCount, 32'd6);
    end
    en = 1'b1;
    load_m(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("adv_cnt",   RetireCount, 32'd7);
    chk("adv_valid", {31'h0, ValidW}, 32'h0);
    step();
    chk("bub_cnt",   RetireCount, 32'd7);

    // flush while stalled
    load_m(1'b1, 32'h34070077, 32'h0, 32'h00000077, 32'h0);
    step();
    chk("pre_fl_valid", {31'h0, ValidW}, 32'h1);
    en = 1'b0; flush = 1'b1;
    step();
    chk("fl_valid", {31'h0, ValidW}, 32'h0);
    chk("fl_instr", InstrW, 32'h0);
    chk("fl_we",    {31'h0, WE}, 32'h0);
    chk("fl_cnt",   RetireCount, 32'd7);
    flush = 1'b0; en = 1'b1;
    load_m(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("post_fl_cnt", RetireCount, 32'd7);

    // asynchronous reset mid-cycle
    load_m(1'b1, 32'h34051234, 32'h0, 32'h00001234, 32'h0);
    step();
    step();
    ctl(1'b1, 2'd0, 2'd0);
    chk("pre_ar_we", {31'h0, WE}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'h0, ValidW}, 32'h0);
    chk("ar_we",    {31'h0, WE}, 32'h0);
    chk("ar_instr", InstrW, 32'h0);
    chk("ar_cnt",   RetireCount, 32'd0);
    chk("ar_cnt4",  {28'h0, RetireCount4}, 32'd0);
    #1 rst_n = 1'b1;

    // 18 edges with valid input retire 17 instructions
    load_m(1'b1, 32'h34051234, 32'h0, 32'h00001234, 32'h0);
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i >= 16) begin
        chk("wrap_cnt4", {28'h0, RetireCount4}, (i - 1) % 16);
        chk("wrap_cnt",  RetireCount, i - 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
